// File: rtl/fifo_flex_pkg.sv
// Shared types and constants for fifo_flex: count width helper, default
// thresholds and the per-cycle operation class.
package fifo_flex_pkg;

   localparam int DEF_B      = 8;
   localparam int DEF_W      = 3;
   localparam int DEF_AE_LVL = 1;

   typedef enum logic [1:0] {
      NOP  = 2'b00,
      WR   = 2'b01,
      RD   = 2'b10,
      WRRD = 2'b11
   } op_e;

   // Occupancy needs one extra bit so that a completely full FIFO (D) is representable.
   function automatic int cnt_width(input int w);
      return w + 1;
   endfunction

endpackage

// File: rtl/fifo_flex_ctrl.sv
// Pointer, occupancy and flag control for fifo_flex.
// Optional FIFO_FLUSH_EN adds a synchronous flush input.
module fifo_flex_ctrl
   import fifo_flex_pkg::*;
#(
   parameter int W      = DEF_W,
   parameter int AF_LVL = (2**W) - 1,
   parameter int AE_LVL = DEF_AE_LVL
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef FIFO_FLUSH_EN
   input  logic                    flush,
`endif
   input  logic                    wr,
   input  logic                    rd,
   input  logic                    clr_err,
   output logic                    we,
   output logic [W-1:0]            w_ptr,
   output logic [W-1:0]            r_ptr,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [cnt_width(W)-1:0] count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int CW = cnt_width(W);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(2**W);
   localparam logic [CW-1:0] AF_CNT    = CW'(AF_LVL);
   localparam logic [CW-1:0] AE_CNT    = CW'(AE_LVL);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
   localparam logic [W-1:0]  PTR_ONE   = W'(1'b1);

   if ((AF_LVL < 1) || (AF_LVL > (2**W))) begin : g_bad_af_lvl
      $error("fifo_flex_ctrl: AF_LVL out of range 1..D");
   end
   if ((AE_LVL < 0) || (AE_LVL > ((2**W) - 1))) begin : g_bad_ae_lvl
      $error("fifo_flex_ctrl: AE_LVL out of range 0..D-1");
   end

   logic [W-1:0]  w_ptr_q, w_ptr_d;
   logic [W-1:0]  r_ptr_q, r_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          almost_full_q, almost_full_d;
   logic          almost_empty_q, almost_empty_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          flush_s;
   logic          rd_acc_s;
   logic          wr_acc_s;
   logic          ovf_set_s;
   logic          udf_set_s;
   op_e           op_s;

`ifdef FIFO_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   // Acceptance, operation class and next-state of pointers, count and flags.
   always_comb begin
      w_ptr_d   = w_ptr_q;
      r_ptr_d   = r_ptr_q;
      count_d   = count_q;
      rd_acc_s  = 1'b0;
      wr_acc_s  = 1'b0;
      ovf_set_s = 1'b0;
      udf_set_s = 1'b0;

      if (flush_s) begin
         rd_acc_s = 1'b0;
         wr_acc_s = 1'b0;
      end else begin
         // A full FIFO still takes a write when the head leaves in the same cycle.
         rd_acc_s  = rd & ~empty_q;
         wr_acc_s  = wr & (~full_q | rd_acc_s);
         ovf_set_s = wr & full_q & ~rd_acc_s;
         udf_set_s = rd & empty_q;
      end

      op_s = op_e'({rd_acc_s, wr_acc_s});

      case (op_s)
         NOP: begin
            count_d = count_q;
         end
         WR: begin
            w_ptr_d = w_ptr_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
         end
         RD: begin
            r_ptr_d = r_ptr_q + PTR_ONE;
            count_d = count_q - CNT_ONE;
         end
         WRRD: begin
            w_ptr_d = w_ptr_q + PTR_ONE;
            r_ptr_d = r_ptr_q + PTR_ONE;
            count_d = count_q;
         end
         default: begin
            count_d = count_q;
         end
      endcase

      if (flush_s) begin
         w_ptr_d = {W{1'b0}};
         r_ptr_d = {W{1'b0}};
         count_d = {CW{1'b0}};
      end else begin
         count_d = count_d;
      end

      full_d         = (count_d == DEPTH_CNT);
      empty_d        = (count_d == {CW{1'b0}});
      almost_full_d  = (count_d >= AF_CNT);
      almost_empty_d = (count_d <= AE_CNT);

      // Set has priority over a simultaneous clear.
      if (ovf_set_s) begin
         overflow_d = 1'b1;
      end else if (clr_err) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end

      if (udf_set_s) begin
         underflow_d = 1'b1;
      end else if (clr_err) begin
         underflow_d = 1'b0;
      end else begin
         underflow_d = underflow_q;
      end
   end

   // State registers with asynchronous reset to the empty condition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_ptr_q        <= {W{1'b0}};
         r_ptr_q        <= {W{1'b0}};
         count_q        <= {CW{1'b0}};
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         w_ptr_q        <= w_ptr_d;
         r_ptr_q        <= r_ptr_d;
         count_q        <= count_d;
         full_q         <= full_d;
         empty_q        <= empty_d;
         almost_full_q  <= almost_full_d;
         almost_empty_q <= almost_empty_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   assign we           = wr_acc_s;
   assign w_ptr        = w_ptr_q;
   assign r_ptr        = r_ptr_q;
   assign count        = count_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: rtl/fifo_flex.sv
// Single-clock show-ahead FIFO with occupancy, thresholds and sticky errors.
// Optional FIFO_FLUSH_EN adds a synchronous flush input.
module fifo_flex
   import fifo_flex_pkg::*;
#(
   parameter int B      = DEF_B,
   parameter int W      = DEF_W,
   parameter int AF_LVL = (2**W) - 1,
   parameter int AE_LVL = DEF_AE_LVL
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef FIFO_FLUSH_EN
   input  logic                    flush,
`endif
   input  logic                    wr,
   input  logic                    rd,
   input  logic [B-1:0]            w_data,
   input  logic                    clr_err,
   output logic [B-1:0]            r_data,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [cnt_width(W)-1:0] count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int D = 2**W;

   logic [B-1:0] mem_q [D];
   logic         we_s;
   logic [W-1:0] w_ptr_s;
   logic [W-1:0] r_ptr_s;

   fifo_flex_ctrl #(
      .W      (W),
      .AF_LVL (AF_LVL),
      .AE_LVL (AE_LVL)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
`ifdef FIFO_FLUSH_EN
      .flush        (flush),
`endif
      .wr           (wr),
      .rd           (rd),
      .clr_err      (clr_err),
      .we           (we_s),
      .w_ptr        (w_ptr_s),
      .r_ptr        (r_ptr_s),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Storage is deliberately not reset; only accepted writes touch it.
   always_ff @(posedge clk) begin
      if (we_s) begin
         mem_q[w_ptr_s] <= w_data;
      end
   end

   assign r_data = mem_q[r_ptr_s];

endmodule
